// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IFU = 2'd1,
        BUSY_LSU = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_req_t;

    localparam logic [1:0]  IFU_SIZE_WORD = 2'b10;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

    // Fetches are always aligned word reads.
    function automatic mem_req_t ifu_req(input logic [31:0] addr);
        mem_req_t r;
        r = '0;
        r.addr = addr;
        r.size = IFU_SIZE_WORD;
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU,
// with a response watchdog and per-requester grant counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ifu_reqValid,
    input  logic [31:0]      ifu_addr,
    output logic             ifu_respValid,
    output logic [31:0]      ifu_rdata,
    input  logic             lsu_reqValid,
    input  logic [31:0]      lsu_addr,
    input  logic [1:0]       lsu_size,
    input  logic             lsu_wen,
    input  logic [31:0]      lsu_wdata,
    input  logic [3:0]       lsu_wmask,
    output logic             lsu_respValid,
    output logic [31:0]      lsu_rdata,
    output logic             mem_reqValid,
    output logic [31:0]      mem_addr,
    output logic [1:0]       mem_size,
    output logic             mem_wen,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wmask,
    input  logic             mem_respValid,
    input  logic [31:0]      mem_rdata,
    output logic             timeout_err,
    output logic [CNT_W-1:0] ifu_grants,
    output logic [CNT_W-1:0] lsu_grants
);

    localparam int unsigned WD_W =
        (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT =
        WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit WD_EN = (TIMEOUT != 0);

    arb_state_t       state_q, state_d;
    mem_req_t         req_q, req_d;
    logic             last_lsu_q, last_lsu_d;
    logic [CNT_W-1:0] ifu_cnt_q, ifu_cnt_d;
    logic [CNT_W-1:0] lsu_cnt_q, lsu_cnt_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;

    logic        busy;
    logic        wd_fire;
    logic        done;
    logic        pick_ifu;
    logic        pick_lsu;
    logic [31:0] rsp_data;
    mem_req_t    lsu_in;
    mem_req_t    mem_out;

    assign busy = (state_q != IDLE);

    // A real response in the limit cycle beats the watchdog.
    assign wd_fire = busy && WD_EN
                   && (wdog_q == WD_LIMIT)
                   && !mem_respValid;
    assign done     = busy && (mem_respValid || wd_fire);
    assign rsp_data = wd_fire ? TIMEOUT_RDATA : mem_rdata;

    always_comb begin
        lsu_in       = '0;
        lsu_in.addr  = lsu_addr;
        lsu_in.size  = lsu_size;
        lsu_in.wen   = lsu_wen;
        lsu_in.wdata = lsu_wdata;
        lsu_in.wmask = lsu_wmask;
    end

    // On a tie the requester not served last wins.
    always_comb begin
        pick_ifu = 1'b0;
        pick_lsu = 1'b0;
        if (state_q == IDLE) begin
            if (ifu_reqValid && lsu_reqValid) begin
                pick_lsu = !last_lsu_q;
                pick_ifu = last_lsu_q;
            end else begin
                pick_lsu = lsu_reqValid;
                pick_ifu = ifu_reqValid;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        last_lsu_d = last_lsu_q;
        ifu_cnt_d  = ifu_cnt_q;
        lsu_cnt_d  = lsu_cnt_q;
        wdog_d     = wdog_q;
        case (state_q)
            IDLE: begin
                if (pick_lsu) begin
                    state_d    = BUSY_LSU;
                    req_d      = lsu_in;
                    last_lsu_d = 1'b1;
                    lsu_cnt_d  = lsu_cnt_q + CNT_W'(1);
                    wdog_d     = '0;
                end else if (pick_ifu) begin
                    state_d    = BUSY_IFU;
                    req_d      = ifu_req(ifu_addr);
                    last_lsu_d = 1'b0;
                    ifu_cnt_d  = ifu_cnt_q + CNT_W'(1);
                    wdog_d     = '0;
                end
            end
            BUSY_IFU, BUSY_LSU: begin
                wdog_d = wdog_q + WD_W'(1);
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= '0;
            last_lsu_q <= 1'b0;
            ifu_cnt_q  <= '0;
            lsu_cnt_q  <= '0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            last_lsu_q <= last_lsu_d;
            ifu_cnt_q  <= ifu_cnt_d;
            lsu_cnt_q  <= lsu_cnt_d;
            wdog_q     <= wdog_d;
        end
    end

    assign mem_out      = busy ? req_q : '0;
    assign mem_reqValid = busy;
    assign mem_addr     = mem_out.addr;
    assign mem_size     = mem_out.size;
    assign mem_wen      = mem_out.wen;
    assign mem_wdata    = mem_out.wdata;
    assign mem_wmask    = mem_out.wmask;

    // A response racing a synchronous reset is dropped.
    assign ifu_respValid = (state_q == BUSY_IFU)
                         && done && !reset;
    assign lsu_respValid = (state_q == BUSY_LSU)
                         && done && !reset;
    assign ifu_rdata = (state_q == BUSY_IFU) ? rsp_data : '0;
    assign lsu_rdata = (state_q == BUSY_LSU) ? rsp_data : '0;
    assign timeout_err = wd_fire && !reset;

    assign ifu_grants = ifu_cnt_q;
    assign lsu_grants = lsu_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter, checked against a
// transaction-level model of arbitration, latency and watchdog.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int TMO = 16;
    localparam int CW  = 8;

    logic          clock;
    logic          reset;
    logic          ifu_reqValid;
    logic [31:0]   ifu_addr;
    logic          ifu_respValid;
    logic [31:0]   ifu_rdata;
    logic          lsu_reqValid;
    logic [31:0]   lsu_addr;
    logic [1:0]    lsu_size;
    logic          lsu_wen;
    logic [31:0]   lsu_wdata;
    logic [3:0]    lsu_wmask;
    logic          lsu_respValid;
    logic [31:0]   lsu_rdata;
    logic          mem_reqValid;
    logic [31:0]   mem_addr;
    logic [1:0]    mem_size;
    logic          mem_wen;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wmask;
    logic          mem_respValid;
    logic [31:0]   mem_rdata;
    logic          timeout_err;
    logic [CW-1:0] ifu_grants;
    logic [CW-1:0] lsu_grants;

    mem_arbiter #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
        .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
        .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr),
        .lsu_size(lsu_size), .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata),
        .mem_reqValid(mem_reqValid), .mem_addr(mem_addr),
        .mem_size(mem_size), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_respValid(mem_respValid), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err),
        .ifu_grants(ifu_grants), .lsu_grants(lsu_grants)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          gap;
    } rq_t;

    typedef struct {
        int            cyc;
        bit            lsu;
        logic [31:0]   addr;
        logic [1:0]    size;
        logic          wen;
        logic [31:0]   wdata;
        logic [3:0]    wmask;
        logic [CW-1:0] ig;
        logic [CW-1:0] lg;
    } xreq_t;

    typedef struct {
        int          cyc;
        bit          lsu;
        logic [31:0] rdata;
        bit          tmo;
    } xrsp_t;

    int total;
    int bad;
    int cyc;
    bit exp_rv;
    xreq_t req_sb[$];
    xrsp_t rsp_sb[$];

    rq_t         ifu_plan[$];
    rq_t         lsu_plan[$];
    int          lat_plan[$];
    logic [31:0] rd_plan[$];
    bit          ifu_act;
    bit          lsu_act;
    rq_t         ifu_cur;
    rq_t         lsu_cur;
    int          owner;
    int          bcnt;
    int          lat;
    bit          m_last_lsu;
    logic [CW-1:0] m_ig;
    logic [CW-1:0] m_lg;

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h",
                     nm, cyc, act, exp);
        end
    endfunction

    function automatic void fail(input string nm,
                                 input int got,
                                 input int want);
        total++;
        bad++;
        $display("FAIL %s cyc=%0d got=%0d want=%0d",
                 nm, cyc, got, want);
    endfunction

    function automatic rq_t mk(input logic [31:0] a,
                               input logic [1:0] s,
                               input logic w,
                               input logic [31:0] d,
                               input logic [3:0] m,
                               input int g);
        rq_t r;
        r.addr = a;
        r.size = s;
        r.wen = w;
        r.wdata = d;
        r.wmask = m;
        r.gap = g;
        return r;
    endfunction

    function automatic rq_t rnd_rq();
        return mk($urandom, 2'($urandom), 1'($urandom),
                  $urandom, 4'($urandom),
                  int'($urandom_range(3)));
    endfunction

    function automatic int rnd_lat();
        if ($urandom_range(9) == 0) return 40;
        return int'($urandom_range(6, 1));
    endfunction

    task automatic step(input bit rst, input bit force_resp);
        bit    resp;
        bit    tmo;
        bit    pick_l;
        bit    pick_i;
        rq_t   t;
        xreq_t xq;
        xrsp_t xs;
        @(negedge clock);
        cyc++;
        reset = rst;
        if (rst) begin
            ifu_plan.delete();
            lsu_plan.delete();
            ifu_act = 1'b0;
            lsu_act = 1'b0;
        end else begin
            if (!ifu_act && ifu_plan.size() > 0) begin
                t = ifu_plan.pop_front();
                if (t.gap > 0) begin
                    t.gap--;
                    ifu_plan.push_front(t);
                end else begin
                    ifu_cur = t;
                    ifu_act = 1'b1;
                end
            end
            if (!lsu_act && lsu_plan.size() > 0) begin
                t = lsu_plan.pop_front();
                if (t.gap > 0) begin
                    t.gap--;
                    lsu_plan.push_front(t);
                end else begin
                    lsu_cur = t;
                    lsu_act = 1'b1;
                end
            end
        end
        // Granted requester keeps valid but scrambles its fields.
        ifu_reqValid = ifu_act;
        ifu_addr = (ifu_act && owner != 1) ? ifu_cur.addr : $urandom;
        lsu_reqValid = lsu_act;
        if (lsu_act && owner != 2) begin
            lsu_addr  = lsu_cur.addr;
            lsu_size  = lsu_cur.size;
            lsu_wen   = lsu_cur.wen;
            lsu_wdata = lsu_cur.wdata;
            lsu_wmask = lsu_cur.wmask;
        end else begin
            lsu_addr  = $urandom;
            lsu_size  = 2'($urandom);
            lsu_wen   = 1'($urandom);
            lsu_wdata = $urandom;
            lsu_wmask = 4'($urandom);
        end
        mem_rdata = $urandom;
        resp = 1'b0;
        if (owner != 0) begin
            if (!rst) begin
                bcnt++;
                resp = (bcnt == lat);
            end
        end else begin
            resp = force_resp || ($urandom_range(7) == 0);
        end
        if (resp && owner != 0 && rd_plan.size() > 0)
            mem_rdata = rd_plan.pop_front();
        mem_respValid = resp;
        exp_rv = (owner != 0);
        if (rst) begin
            owner = 0;
            m_last_lsu = 1'b0;
            m_ig = '0;
            m_lg = '0;
        end else if (owner != 0) begin
            tmo = !resp && (bcnt == TMO);
            if (resp || tmo) begin
                xs.cyc = cyc;
                xs.lsu = (owner == 2);
                xs.rdata = tmo ? 32'hDEADBEEF : mem_rdata;
                xs.tmo = tmo;
                rsp_sb.push_back(xs);
                if (owner == 1) ifu_act = 1'b0;
                else lsu_act = 1'b0;
                owner = 0;
            end
        end else begin
            pick_l = lsu_act && (!ifu_act || !m_last_lsu);
            pick_i = ifu_act && !pick_l;
            if (pick_i || pick_l) begin
                xq.cyc = cyc + 1;
                xq.lsu = pick_l;
                if (pick_l) begin
                    xq.addr  = lsu_cur.addr;
                    xq.size  = lsu_cur.size;
                    xq.wen   = lsu_cur.wen;
                    xq.wdata = lsu_cur.wdata;
                    xq.wmask = lsu_cur.wmask;
                    m_lg++;
                end else begin
                    xq.addr  = ifu_cur.addr;
                    xq.size  = 2'b10;
                    xq.wen   = 1'b0;
                    xq.wdata = '0;
                    xq.wmask = '0;
                    m_ig++;
                end
                m_last_lsu = pick_l;
                xq.ig = m_ig;
                xq.lg = m_lg;
                req_sb.push_back(xq);
                owner = pick_l ? 2 : 1;
                bcnt = 0;
                lat = (lat_plan.size() > 0) ?
                      lat_plan.pop_front() : rnd_lat();
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((ifu_plan.size() > 0 || lsu_plan.size() > 0
                || ifu_act || lsu_act || owner != 0)
               && n < budget) begin
            step(1'b0, 1'b0);
            n++;
        end
        if (n >= budget) fail("drain_budget", n, budget);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_reqValid"}, mem_reqValid, 0);
        chk({tag, "_mem_fields"},
            mem_addr | mem_wdata | 32'(mem_size)
            | 32'(mem_wen) | 32'(mem_wmask), 0);
        chk({tag, "_respValid"},
            32'({ifu_respValid, lsu_respValid}), 0);
        chk({tag, "_rdata"}, ifu_rdata | lsu_rdata, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_ifu_grants"}, ifu_grants, 0);
        chk({tag, "_lsu_grants"}, lsu_grants, 0);
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents them.
    initial begin
        bit    prev_rv;
        xreq_t cur;
        xreq_t e;
        xrsp_t r;
        prev_rv = 1'b0;
        forever begin
            @(negedge clock);
            #2;
            chk("mem_reqValid", mem_reqValid, exp_rv);
            if (mem_reqValid && !prev_rv) begin
                if (req_sb.size() == 0) begin
                    fail("req_unexpected", 1, 0);
                end else begin
                    e = req_sb.pop_front();
                    cur = e;
                    chk("grant_cycle", cyc, e.cyc);
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_size", mem_size, e.size);
                    chk("mem_wen", mem_wen, e.wen);
                    chk("mem_wdata", mem_wdata, e.wdata);
                    chk("mem_wmask", mem_wmask, e.wmask);
                    chk("ifu_grants", ifu_grants, e.ig);
                    chk("lsu_grants", lsu_grants, e.lg);
                end
            end else if (mem_reqValid) begin
                chk("hold_addr", mem_addr, cur.addr);
                chk("hold_wdata", mem_wdata, cur.wdata);
                chk("hold_ctl",
                    {mem_size, mem_wen, mem_wmask},
                    {cur.size, cur.wen, cur.wmask});
            end
            prev_rv = mem_reqValid;
            if (ifu_respValid || lsu_respValid || timeout_err) begin
                if (rsp_sb.size() == 0) begin
                    fail("rsp_unexpected", 1, 0);
                end else begin
                    r = rsp_sb.pop_front();
                    chk("rsp_cycle", cyc, r.cyc);
                    chk("ifu_respValid", ifu_respValid, !r.lsu);
                    chk("lsu_respValid", lsu_respValid, r.lsu);
                    chk("resp_rdata",
                        r.lsu ? lsu_rdata : ifu_rdata, r.rdata);
                    chk("timeout_err", timeout_err, r.tmo);
                end
            end else if (rsp_sb.size() > 0
                         && rsp_sb[0].cyc <= cyc) begin
                r = rsp_sb.pop_front();
                fail("rsp_missing", 0, r.cyc);
            end
        end
    end

    initial begin
        int n;
        total = 0;
        bad = 0;
        cyc = 0;
        owner = 0;
        bcnt = 0;
        lat = 0;
        exp_rv = 1'b0;
        m_last_lsu = 1'b0;
        m_ig = '0;
        m_lg = '0;
        reset = 1'b1;
        ifu_reqValid = 1'b0;
        ifu_addr = '0;
        lsu_reqValid = 1'b0;
        lsu_addr = '0;
        lsu_size = '0;
        lsu_wen = 1'b0;
        lsu_wdata = '0;
        lsu_wmask = '0;
        mem_respValid = 1'b0;
        mem_rdata = '0;

        repeat (3) step(1'b1, 1'b0);
        #2;
        chk_quiet("reset");

        // Single fetch, answered on the fourth busy cycle.
        ifu_plan.push_back(mk(32'h8000_0000, 0, 0, 0, 0, 0));
        lat_plan.push_back(4);
        rd_plan.push_back(32'h0000_0413);
        drain(100);

        // Tie straight out of reset: LSU store first, then IFU.
        step(1'b1, 1'b0);
        ifu_plan.push_back(mk(32'h8000_0004, 0, 0, 0, 0, 0));
        lsu_plan.push_back(mk(32'h8000_1000, 2'b10, 1'b1,
                              32'hCAFE_BABE, 4'b1111, 0));
        drain(100);

        // Sustained contention: four back-to-back from each side.
        step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ifu_plan.push_back(mk($urandom, 0, 0, 0, 0, 0));
            lsu_plan.push_back(rnd_rq());
            lsu_plan[$].gap = 0;
        end
        drain(400);
        chk("contend_ifu_grants", ifu_grants, 4);
        chk("contend_lsu_grants", lsu_grants, 4);

        // Watchdog: silent memory, response exactly at limit, one short.
        lsu_plan.push_back(mk(32'h8000_2000, 2'b10, 0, 0, 0, 0));
        lat_plan.push_back(100);
        drain(100);
        step(1'b0, 1'b1);
        lsu_plan.push_back(mk(32'h8000_2004, 2'b01, 0, 0, 0, 0));
        lsu_plan.push_back(mk(32'h8000_2008, 2'b00, 0, 0, 0, 0));
        lat_plan.push_back(TMO);
        lat_plan.push_back(TMO - 1);
        drain(100);

        // Random mix, long enough for the counters to wrap.
        for (int i = 0; i < 300; i++) begin
            ifu_plan.push_back(rnd_rq());
            lsu_plan.push_back(rnd_rq());
        end
        drain(30000);

        // Reset during an outstanding fetch, then a late response.
        ifu_plan.push_back(mk(32'h8000_0100, 0, 0, 0, 0, 0));
        lat_plan.push_back(100);
        n = 0;
        while (!(owner == 1 && bcnt >= 2) && n < 50) begin
            step(1'b0, 1'b0);
            n++;
        end
        if (n >= 50) fail("midreset_setup", n, 50);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        #2;
        chk_quiet("midreset");
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        if (req_sb.size() != 0)
            fail("req_leftover", req_sb.size(), 0);
        if (rsp_sb.size() != 0)
            fail("rsp_leftover", rsp_sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one memory port between the CPU's instruction-fetch (IFU) and load/store (LSU) interfaces. It sits between the cpu core and the SoC memory/bus bridge. Each request is registered and granted round-robin. The downstream request is held until the memory responds, and the response is routed back to the granted requester. A timeout watchdog and grant counters support debug.

## Interface
- `TIMEOUT`, default 1024: cycles without `mem_respValid` before a watchdog error response; 0 disables the watchdog.
- `CNT_W`, default 32: width of the grant counters.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ifu_reqValid` in 1; `ifu_addr` in 32: fetch request, level-held until `ifu_respValid`.
- `ifu_respValid` out 1; `ifu_rdata` out 32: fetch response.
- `lsu_reqValid` in 1; `lsu_addr` in 32; `lsu_size` in 2; `lsu_wen` in 1; `lsu_wdata` in 32; `lsu_wmask` in 4: LSU request, level-held until `lsu_respValid`.
- `lsu_respValid` out 1; `lsu_rdata` out 32: LSU response.
- `mem_reqValid` out 1; `mem_addr` out 32; `mem_size` out 2; `mem_wen` out 1; `mem_wdata` out 32; `mem_wmask` out 4: downstream request.
- `mem_respValid` in 1; `mem_rdata` in 32: downstream response, one-cycle pulse.
- `timeout_err` out 1: one-cycle pulse when the watchdog fires.
- `ifu_grants` out CNT_W; `lsu_grants` out CNT_W: count of grants issued, wrapping at 2^CNT_W.

## Operation
- States:
  - IDLE: no access outstanding.
  - BUSY_IFU: IFU access outstanding downstream.
  - BUSY_LSU: LSU access outstanding downstream.
- Leaving IDLE:
  - Only one requester valid: grant it.
  - Both valid: grant the requester not granted last (`last_lsu` flag). After reset, `last_lsu`=0, so LSU wins the first tie.
  - On grant, latch all request fields into a request register and increment that requester's grant counter.
- IFU grant forces `mem_size`=2'b10, `mem_wen`=0, `mem_wdata`=0 and `mem_wmask`=4'b0000.
- While BUSY_x:
  - `mem_reqValid`=1.
  - `mem_*` fields come only from the latched register; requester input changes are ignored.
- Response routing:
  - `x_respValid` = `mem_respValid` && state==BUSY_x, combinational.
  - `x_rdata` = `mem_rdata` whenever state==BUSY_x, else 0.
  - The same cycle, the next state is IDLE.
- `mem_respValid` while IDLE is ignored and not forwarded.
- Watchdog:
  - A counter clears on grant and increments each BUSY cycle.
  - When it reaches `TIMEOUT`-1 without a response, the arbiter pulses `x_respValid` with `x_rdata`=32'hDEADBEEF, pulses `timeout_err` and goes to IDLE.
  - A late `mem_respValid` is then dropped.

## Timing
- Reset: state IDLE, `last_lsu`=0, counters 0, watchdog 0. All outputs are 0.
- Reset mid-transaction returns to IDLE next cycle. The in-flight response is discarded and no `respValid` is produced.
- Request path latency:
  - Request first high in IDLE at cycle N gives `mem_reqValid`=1 at N+1, with fields equal to the inputs sampled at N.
- Response path latency:
  - `mem_respValid` at cycle M gives `x_respValid`=1 at M (zero latency) and state IDLE at M+1.
  - The earliest next grant is registered at the end of M+1 and appears downstream at M+2.
  - There is one idle bubble between back-to-back accesses.
- A requester holding `reqValid` at M+1 is treated as a new request.
- Response in the same cycle the watchdog reaches its limit: the real response wins and `timeout_err` stays 0.
- `mem_respValid` at cycle N+1 (first BUSY cycle) is legal.
- Counters wrap silently.

## Structure
- Shared package `mem_arb_pkg`: state enum `arb_state_t` (IDLE, BUSY_IFU, BUSY_LSU), packed struct `mem_req_t` (addr, size, wen, wdata, wmask), constants `IFU_SIZE_WORD`=2'b10 and `TIMEOUT_RDATA`=32'hDEADBEEF.
- The block is a single module with no sub-modules.
- The request register is a `mem_req_t`.

## Test plan
- IFU-only fetch:
  - Stimulus: `ifu_reqValid`, addr 0x8000_0000, memory responds 3 cycles later with 0x0000_0413.
  - Response: `mem_addr`=0x8000_0000, `mem_wen`=0, `ifu_respValid` pulses with 0x0000_0413, `ifu_grants`=1.
- Simultaneous requests from reset:
  - Stimulus: IFU 0x8000_0004 and LSU store 0x8000_1000 (wdata 0xCAFEBABE, wmask 4'b1111), both held.
  - Response: LSU granted first, IFU second, IFU request reaches downstream exactly 2 cycles after the LSU response.
- Sustained contention:
  - Stimulus: both requesters re-request immediately for 8 transactions.
  - Response: strictly alternating grants, `ifu_grants`=`lsu_grants`=4.
- Field stability:
  - Stimulus: change `lsu_addr` and `lsu_wdata` while BUSY_LSU.
  - Response: `mem_addr` and `mem_wdata` keep the granted values.
- Watchdog:
  - Stimulus: `TIMEOUT`=16, memory never responds to an LSU load.
  - Response: at BUSY cycle 16, `lsu_respValid`=1 with 0xDEADBEEF and `timeout_err`=1. A later stray `mem_respValid` is ignored.
- Reset mid-operation:
  - Stimulus: assert `reset` during BUSY_IFU, then `mem_respValid`.
  - Response: no `ifu_respValid`, all outputs 0, counters 0.
